// File: rtl/frost_io_pkg.sv
// Shared register offsets, CTRL bit positions and byte-lane helpers for the GPIO/timer peripheral.
package frost_io_pkg;

    localparam logic [3:0] OFF_OUT   = 4'd0;
    localparam logic [3:0] OFF_SET   = 4'd1;
    localparam logic [3:0] OFF_CLR   = 4'd2;
    localparam logic [3:0] OFF_TGL   = 4'd3;
    localparam logic [3:0] OFF_IN    = 4'd4;
    localparam logic [3:0] OFF_EDGE  = 4'd5;
    localparam logic [3:0] OFF_COUNT = 4'd6;
    localparam logic [3:0] OFF_CMP   = 4'd7;
    localparam logic [3:0] OFF_CTRL  = 4'd8;
    localparam logic [3:0] OFF_STAT  = 4'd9;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_ACLR = 1;
    localparam int CTRL_EIE  = 2;
    localparam int CTRL_MIE  = 3;

    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{we[i]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] apply_lanes(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  we);
        logic [31:0] m;
        m = lane_mask(we);
        return (old & ~m) | (wdata & m);
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop synchroniser for asynchronous GPIO inputs plus a third flop for rising-edge detect.
// Latency: in_sync is 2 clk behind the pin; rise pulses for one clk in the cycle in_sync first reads 1.
// Backpressure: none; free-running.
module gpio_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] in_sync,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1_q, s2_q, s3_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= d_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign in_sync = s2_q;
    assign rise    = s2_q & ~s3_q;

endmodule

// File: rtl/mmio_gpio_timer.sv
// Word-bus peripheral: GPIO out with set/clear/toggle aliases, synchronised inputs with edge capture, compare timer, level irq.
// Latency: writes land on the next clk; read data and rd_hit are registered, valid 1 clk after re.
// Backpressure: none; every bus access completes in a single cycle.
module mmio_gpio_timer
    import frost_io_pkg::*;
#(
    parameter logic [29:0]       BASE    = 30'h0100,
    parameter int                GPIO_W  = 8,
    parameter logic [GPIO_W-1:0] OUT_RST = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        we,
    input  logic              re,
    output logic [31:0]       rdata,
    output logic              rd_hit,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    logic              hit;
    logic [3:0]        off;
    logic [GPIO_W-1:0] in_sync, rise;

    logic [GPIO_W-1:0] out_q, out_d;
    logic [GPIO_W-1:0] edge_q, edge_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       cmp_q, cmp_d;
    logic [3:0]        ctrl_q, ctrl_d;
    logic              match_q, match_d;
    logic              irq_q, irq_d;
    logic              rd_hit_q, rd_hit_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       out_ext, in_ext, edge_ext, out_wr, wmask, rsel;
    logic [GPIO_W-1:0] edge_clr;
    logic              match_now;
    logic              unused_bits;

    assign hit = (addr[29:4] == BASE[29:4]);
    assign off = addr[3:0];

    gpio_sync_edge #(.W(GPIO_W)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .d_in    (gpio_in),
        .in_sync (in_sync),
        .rise    (rise)
    );

    always_comb begin
        out_ext  = '0;
        in_ext   = '0;
        edge_ext = '0;
        out_ext[GPIO_W-1:0]  = out_q;
        in_ext[GPIO_W-1:0]   = in_sync;
        edge_ext[GPIO_W-1:0] = edge_q;
    end

    // wmask holds only the written bits of enabled lanes; w1s/w1c/w1t all key off it.
    assign out_wr      = apply_lanes(out_ext, wdata, we);
    assign wmask       = wdata & lane_mask(we);
    assign match_now   = ctrl_q[CTRL_RUN] && (count_q == cmp_q);
    assign unused_bits = ^{out_wr, wmask};

    always_comb begin
        out_d    = out_q;
        cmp_d    = cmp_q;
        ctrl_d   = ctrl_q;
        edge_clr = '0;
        if (hit) begin
            case (off)
                OFF_OUT:  out_d    = out_wr[GPIO_W-1:0];
                OFF_SET:  out_d    = out_q | wmask[GPIO_W-1:0];
                OFF_CLR:  out_d    = out_q & ~wmask[GPIO_W-1:0];
                OFF_TGL:  out_d    = out_q ^ wmask[GPIO_W-1:0];
                OFF_EDGE: edge_clr = wmask[GPIO_W-1:0];
                OFF_CMP:  cmp_d    = apply_lanes(cmp_q, wdata, we);
                OFF_CTRL: if (we[0]) ctrl_d = wdata[3:0];
                default: ;
            endcase
        end

        // Hardware sets are OR-ed in after the w1c so a coincident event is never lost.
        edge_d  = (edge_q & ~edge_clr) | rise;
        match_d = (match_q & ~(hit && (off == OFF_STAT) && wmask[0])) | match_now;

        count_d = count_q;
        if (ctrl_q[CTRL_RUN]) begin
            count_d = (match_now && ctrl_q[CTRL_ACLR]) ? 32'd0 : count_q + 32'd1;
        end
        if (hit && (off == OFF_COUNT) && (|we)) begin
            count_d = apply_lanes(count_q, wdata, we);
        end

        irq_d = (ctrl_q[CTRL_EIE] && (|edge_q)) || (ctrl_q[CTRL_MIE] && match_q);
    end

    always_comb begin
        rsel = '0;
        case (off)
            OFF_OUT, OFF_SET, OFF_CLR, OFF_TGL: rsel = out_ext;
            OFF_IN:    rsel = in_ext;
            OFF_EDGE:  rsel = edge_ext;
            OFF_COUNT: rsel = count_q;
            OFF_CMP:   rsel = cmp_q;
            OFF_CTRL:  rsel = {28'd0, ctrl_q};
            OFF_STAT:  rsel = {31'd0, match_q};
            default:   rsel = '0;
        endcase
        rd_hit_d = re && hit;
        rdata_d  = rd_hit_d ? rsel : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q    <= OUT_RST;
            edge_q   <= '0;
            count_q  <= '0;
            cmp_q    <= 32'hFFFF_FFFF;
            ctrl_q   <= '0;
            match_q  <= 1'b0;
            irq_q    <= 1'b0;
            rd_hit_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            out_q    <= out_d;
            edge_q   <= edge_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            ctrl_q   <= ctrl_d;
            match_q  <= match_d;
            irq_q    <= irq_d;
            rd_hit_q <= rd_hit_d;
            rdata_q  <= rdata_d;
        end
    end

    assign gpio_out = out_q;
    assign irq      = irq_q;
    assign rd_hit   = rd_hit_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_mmio_gpio_timer.sv
// Bench for mmio_gpio_timer: reads push expected data into a queue, a negedge monitor pops and compares.
module tb_mmio_gpio_timer;

    localparam logic [29:0] BASE    = 30'h0100;
    localparam logic [3:0]  O_OUT   = 4'd0;
    localparam logic [3:0]  O_SET   = 4'd1;
    localparam logic [3:0]  O_CLR   = 4'd2;
    localparam logic [3:0]  O_TGL   = 4'd3;
    localparam logic [3:0]  O_IN    = 4'd4;
    localparam logic [3:0]  O_EDGE  = 4'd5;
    localparam logic [3:0]  O_COUNT = 4'd6;
    localparam logic [3:0]  O_CMP   = 4'd7;
    localparam logic [3:0]  O_CTRL  = 4'd8;
    localparam logic [3:0]  O_STAT  = 4'd9;

    logic        clk;
    logic        reset;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic [31:0] rdata;
    logic        rd_hit;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq;

    mmio_gpio_timer #(.BASE(BASE), .GPIO_W(8), .OUT_RST(8'hA5)) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .rdata    (rdata),
        .rd_hit   (rd_hit),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        hit;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks;
    int   failures;
    logic launched;

    always @(posedge clk) launched <= re;

    always @(negedge clk) begin
        if (launched === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: read returned rdata=%h with nothing expected", rdata);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (rdata !== mon_e.data) begin
                    failures++;
                    $display("FAIL %s: rdata=%h expected %h", mon_e.name, rdata, mon_e.data);
                end
                checks++;
                if (rd_hit !== mon_e.hit) begin
                    failures++;
                    $display("FAIL %s_hit: rd_hit=%b expected %b", mon_e.name, rd_hit, mon_e.hit);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    function automatic logic [29:0] ra(input logic [3:0] off);
        return BASE + {26'd0, off};
    endfunction

    task automatic push_exp(input logic [31:0] d, input logic h, input string nm);
        exp_t e;
        e.data = d;
        e.hit  = h;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] w);
        @(negedge clk);
        addr  = ra(off);
        wdata = d;
        we    = w;
        re    = 1'b0;
        @(negedge clk);
        we = 4'd0;
    endtask

    task automatic rd(input logic [29:0] a, input logic [31:0] d, input logic h, input string nm);
        @(negedge clk);
        addr = a;
        we   = 4'd0;
        re   = 1'b1;
        push_exp(d, h, nm);
        @(negedge clk);
        re = 1'b0;
    endtask

    // Starts the timer with ctrl_v and reads COUNT back-to-back; read k returns the count k clk after run latched.
    task automatic count_stream(input logic [3:0] ctrl_v, input int n, input logic [31:0] start,
                                input int wrap_at, input string nm);
        @(negedge clk);
        addr  = ra(O_CTRL);
        wdata = {28'd0, ctrl_v};
        we    = 4'hF;
        @(negedge clk);
        we   = 4'd0;
        addr = ra(O_COUNT);
        re   = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (k != 0) @(negedge clk);
            if (wrap_at > 0) push_exp(32'(k % wrap_at), 1'b1, nm);
            else             push_exp(start + 32'(k), 1'b1, nm);
        end
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (gpio_out !== 8'hA5) begin failures++; $display("FAIL rst_gpio_out: got %h want a5", gpio_out); end
        checks++;
        if (rdata !== 32'd0) begin failures++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        checks++;
        if (rd_hit !== 1'b0) begin failures++; $display("FAIL rst_rd_hit: got %b want 0", rd_hit); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq: got %b want 0", irq); end
        reset = 1'b0;
        rd(ra(O_OUT),   32'h0000_00A5, 1'b1, "rst_out");
        rd(ra(O_COUNT), 32'd0,         1'b1, "rst_count");
        rd(ra(O_CMP),   32'hFFFF_FFFF, 1'b1, "rst_cmp");
        rd(ra(O_CTRL),  32'd0,         1'b1, "rst_ctrl");
        rd(ra(O_STAT),  32'd0,         1'b1, "rst_stat");
        rd(ra(O_EDGE),  32'd0,         1'b1, "rst_edge");
    endtask

    task automatic test_gpio;
        wr(O_OUT, 32'h0000_000F, 4'hF);
        wr(O_SET, 32'h0000_0030, 4'hF);
        wr(O_CLR, 32'h0000_0001, 4'h1);
        wr(O_TGL, 32'h0000_00FF, 4'h1);
        rd(ra(O_OUT), 32'h0000_00C1, 1'b1, "gpio_out_reg");
        rd(ra(O_TGL), 32'h0000_00C1, 1'b1, "gpio_tgl_alias");
        checks++;
        if (gpio_out !== 8'hC1) begin failures++; $display("FAIL gpio_port: got %h want c1", gpio_out); end
        wr(O_OUT, 32'hFFFF_FFFF, 4'b0010);
        rd(ra(O_OUT), 32'h0000_00C1, 1'b1, "gpio_lane1_ignored");
        wr(4'd12, 32'hFFFF_FFFF, 4'hF);
        rd(ra(O_OUT), 32'h0000_00C1, 1'b1, "gpio_off12_write_ignored");
    endtask

    task automatic test_edge;
        wr(O_CTRL, 32'h4, 4'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                gpio_in[2] = 1'b1;
                addr = ra(O_EDGE);
                we   = 4'd0;
                re   = 1'b1;
            end
            push_exp((k >= 3) ? 32'h4 : 32'h0, 1'b1, "edge_latency");
            if (k == 3) begin
                checks++;
                if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_early: got %b want 0", irq); end
            end
            if (k == 4) begin
                checks++;
                if (irq !== 1'b1) begin failures++; $display("FAIL edge_irq_rise: got %b want 1", irq); end
            end
        end
        @(negedge clk);
        re = 1'b0;
        wr(O_EDGE, 32'h4, 4'h1);
        rd(ra(O_EDGE), 32'h0, 1'b1, "edge_w1c");
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_fall: got %b want 0", irq); end
        gpio_in[2] = 1'b0;
        repeat (4) @(negedge clk);
        rd(ra(O_EDGE), 32'h0, 1'b1, "edge_falling_ignored");
        @(negedge clk);
        gpio_in[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        addr  = ra(O_EDGE);
        wdata = 32'h4;
        we    = 4'h1;
        @(negedge clk);
        we = 4'd0;
        rd(ra(O_EDGE), 32'h4, 1'b1, "edge_set_beats_w1c");
        wr(O_EDGE, 32'h4, 4'h1);
        wr(O_CTRL, 32'h0, 4'h1);
    endtask

    task automatic test_read_path;
        gpio_in = 8'h5A;
        repeat (4) @(negedge clk);
        rd(ra(O_IN), 32'h0000_005A, 1'b1, "rd_in");
        rd(ra(4'd12), 32'd0, 1'b1, "rd_off12");
        rd(30'h0200 + 30'd4, 32'd0, 1'b0, "rd_outside");
        @(negedge clk);
        checks++;
        if (rdata !== 32'd0 || rd_hit !== 1'b0) begin
            failures++;
            $display("FAIL rd_idle: rdata=%h rd_hit=%b want 0/0", rdata, rd_hit);
        end
        wr(O_EDGE, 32'hFF, 4'h1);
        rd(ra(O_EDGE), 32'd0, 1'b1, "rd_edge_cleared");
    endtask

    task automatic test_timer;
        wr(O_CMP, 32'd5, 4'hF);
        wr(O_COUNT, 32'd0, 4'hF);
        count_stream(4'b1011, 14, 32'd0, 6, "timer_autoclear");
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL timer_irq: got %b want 1", irq); end
        rd(ra(O_STAT), 32'd1, 1'b1, "timer_match");
        wr(O_CTRL, 32'h0, 4'h1);
        wr(O_STAT, 32'h1, 4'h1);
        rd(ra(O_STAT), 32'd0, 1'b1, "timer_match_w1c");

        wr(O_COUNT, 32'd0, 4'hF);
        count_stream(4'b1001, 10, 32'd0, 0, "timer_no_autoclear");
        wr(O_CTRL, 32'h0, 4'h1);
        rd(ra(O_STAT), 32'd1, 1'b1, "timer_match_noclr");
        wr(O_STAT, 32'h1, 4'h1);

        wr(O_COUNT, 32'hFFFF_FFFF, 4'hF);
        count_stream(4'b0001, 4, 32'hFFFF_FFFF, 0, "timer_wrap");
        wr(O_CTRL, 32'h0, 4'h1);
    endtask

    task automatic test_collision;
        wr(O_COUNT, 32'd0, 4'hF);
        wr(O_CMP, 32'd3, 4'hF);
        wr(O_STAT, 32'h1, 4'h1);
        rd(ra(O_STAT), 32'd0, 1'b1, "coll_stat_clear");
        @(negedge clk);
        addr  = ra(O_CTRL);
        wdata = 32'h3;
        we    = 4'h1;
        @(negedge clk);
        we = 4'd0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        addr  = ra(O_COUNT);
        wdata = 32'd100;
        we    = 4'hF;
        @(negedge clk);
        we = 4'd0;
        re = 1'b1;
        push_exp(32'd100, 1'b1, "coll_count_write_wins");
        @(negedge clk);
        re = 1'b0;
        wr(O_CTRL, 32'h0, 4'h1);
        rd(ra(O_STAT), 32'd1, 1'b1, "coll_match_sets");
    endtask

    task automatic test_reset_mid;
        wr(O_CMP, 32'd2, 4'hF);
        wr(O_COUNT, 32'd0, 4'hF);
        wr(O_CTRL, 32'h9, 4'h1);
        repeat (8) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL mid_irq_before: got %b want 1", irq); end
        @(negedge clk);
        addr = ra(O_CTRL);
        re   = 1'b1;
        push_exp(32'h9, 1'b1, "mid_ctrl_before");
        @(negedge clk);
        push_exp(32'd0, 1'b0, "mid_pending_read");
        checks++;
        if (rd_hit !== 1'b1) begin failures++; $display("FAIL mid_rd_hit_before: got %b want 1", rd_hit); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rd_hit !== 1'b0 || rdata !== 32'd0) begin
            failures++;
            $display("FAIL mid_rst_read: rd_hit=%b rdata=%h want 0/0", rd_hit, rdata);
        end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL mid_rst_irq: got %b want 0", irq); end
        checks++;
        if (gpio_out !== 8'hA5) begin failures++; $display("FAIL mid_rst_gpio: got %h want a5", gpio_out); end
        @(negedge clk);
        re    = 1'b0;
        reset = 1'b0;
        rd(ra(O_COUNT), 32'd0,         1'b1, "mid_count");
        rd(ra(O_CTRL),  32'd0,         1'b1, "mid_ctrl");
        rd(ra(O_STAT),  32'd0,         1'b1, "mid_stat");
        rd(ra(O_CMP),   32'hFFFF_FFFF, 1'b1, "mid_cmp");
        rd(ra(O_OUT),   32'h0000_00A5, 1'b1, "mid_out");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        addr     = '0;
        wdata    = '0;
        we       = '0;
        re       = 1'b0;
        gpio_in  = '0;

        test_reset();
        test_gpio();
        test_edge();
        test_read_path();
        test_timer();
        test_collision();
        test_reset_mid();

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d expected reads never returned, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
